// File: rtl/mod_pkg.sv
// Shared definitions for the operand queue and the downstream remainder stage.
//   DEF_WIDTH : default operand width in bits
//   DEF_DEPTH : default queue entry count (power of two, >= 2)
//   entry_t   : stored record {a, b, f, zero} at the default width
package mod_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 f;
    logic                 zero;
  } entry_t;

  localparam int unsigned ENTRY_BITS = $bits(entry_t);

endpackage

// File: rtl/mod_queue_mem.sv
// Storage array for the operand queue: one synchronous write port and one
// combinational read port. Contents are not reset; the owner masks outputs
// while no valid entry is present.
//   clk     : clock
//   wr_en   : write strobe, sampled on rising edge
//   wr_addr : write slot
//   wr_data : record to store
//   rd_addr : read slot
//   rd_data : record at rd_addr (combinational)
module mod_queue_mem
  import mod_pkg::*;
#(
  parameter int unsigned ENTRY_W = ENTRY_BITS,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mod_operand_queue.sv
// Operand queue feeding the remainder stage. Accepts {a, b} pairs, computes
// the odd-parity select f = ^a and the divide-by-zero flag at push time and
// stores them with the entry. Registered-count FIFO, one cycle push-to-output
// latency, no fall-through.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : producer handshake; in_ready = count < DEPTH
//   in_a, in_b          : dividend, divisor
//   out_valid/out_ready : consumer handshake; out_valid = count != 0
//   out_a, out_b        : head dividend / divisor (0 when empty)
//   out_f, out_zero     : stored parity select / divisor-is-zero (0 when empty)
//   count               : number of stored entries
module mod_operand_queue
  import mod_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic                     out_f,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Same field order as mod_pkg::entry_t, sized by this instance's WIDTH so
  // non-default widths remain legal.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             f;
    logic             zero;
  } op_entry_t;

  localparam int unsigned EW = $bits(op_entry_t);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  op_entry_t     wr_entry;
  op_entry_t     rd_entry;
  logic [EW-1:0] rd_bits;

  assign in_ready  = (cnt < CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid  && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  always_comb begin
    wr_entry      = '0;
    wr_entry.a    = in_a;
    wr_entry.b    = in_b;
    wr_entry.f    = ^in_a;
    wr_entry.zero = (in_b == '0);
  end

  mod_queue_mem #(
    .ENTRY_W (EW),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_bits)
  );

  assign rd_entry = op_entry_t'(rd_bits);

  // Pointers wrap naturally at AW bits since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    out_a    = '0;
    out_b    = '0;
    out_f    = 1'b0;
    out_zero = 1'b0;
    if (out_valid) begin
      out_a    = rd_entry.a;
      out_b    = rd_entry.b;
      out_f    = rd_entry.f;
      out_zero = rd_entry.zero;
    end
  end

endmodule

// File: tb/tb_mod_operand_queue.sv
module tb_mod_operand_queue;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         out_f;
  logic         out_zero;
  logic [2:0]   count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  pair_t model_q[$];

  mod_operand_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_f     (out_f),
    .out_zero  (out_zero),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of pairs; full/empty judged before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      bit was_full;
      bit do_pop;
      was_full = (model_q.size() == D);
      do_pop   = out_ready && (model_q.size() != 0);
      if (do_pop) void'(model_q.pop_front());
      if (in_valid && !was_full) model_q.push_back('{a: in_a, b: in_b});
    end
  end

  // Compare process: outputs vs model on every falling edge.
  always @(negedge clk) begin
    int n;
    n = model_q.size();
    chk("in_ready",  32'(in_ready),  32'(n < D));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("count",     32'(count),     32'(n));
    if (n != 0) begin
      chk("out_a",    32'(out_a),    32'(model_q[0].a));
      chk("out_b",    32'(out_b),    32'(model_q[0].b));
      chk("out_f",    32'(out_f),    32'(model_q[0].a[0] ^ model_q[0].a[1] ^ model_q[0].a[2] ^ model_q[0].a[3]));
      chk("out_zero", 32'(out_zero), 32'(model_q[0].b == 0));
    end else begin
      chk("out_a_masked",    32'(out_a),    32'd0);
      chk("out_b_masked",    32'(out_b),    32'd0);
      chk("out_f_masked",    32'(out_f),    32'd0);
      chk("out_zero_masked", 32'(out_zero), 32'd0);
    end
  end

  // Drive inputs just after a falling edge, then return 2 time units after
  // the rising edge that consumed them.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_a",     32'(out_a),     32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // First push after release, visible next cycle.
    cycle(1'b1, 4'b0111, 4'd3, 1'b0);
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_a",     32'(out_a),     32'd7);
    chk("p1_b",     32'(out_b),     32'd3);
    chk("p1_f",     32'(out_f),     32'd1);
    chk("p1_zero",  32'(out_zero),  32'd0);
    chk("p1_count", 32'(count),     32'd1);
    cycle(1'b0, '0, '0, 1'b1);
    chk("p1_pop_count", 32'(count), 32'd0);

    // Zero divisor, even parity.
    cycle(1'b1, 4'b0011, 4'd0, 1'b0);
    chk("z_f",    32'(out_f),    32'd0);
    chk("z_zero", 32'(out_zero), 32'd1);
    chk("z_a",    32'(out_a),    32'd3);
    cycle(1'b0, 4'hF, 4'hF, 1'b1);
    chk("z_pop_valid", 32'(out_valid), 32'd0);
    chk("z_pop_a",     32'(out_a),     32'd0);
    chk("z_pop_b",     32'(out_b),     32'd0);
    chk("z_pop_f",     32'(out_f),     32'd0);
    chk("z_pop_zero",  32'(out_zero),  32'd0);

    // Overfill: 5 pushes, 5th dropped.
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 4'(i), 4'(i + 8), 1'b0);
      if (i == 4) chk("full_in_ready", 32'(in_ready), 32'd0);
    end
    chk("full_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_a", 32'(out_a), 32'(i));
      cycle(1'b0, '0, '0, 1'b1);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Full with simultaneous push and pop: pop only.
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 1), 4'd1, 1'b0);
    cycle(1'b1, 4'd9, 4'd9, 1'b1);
    chk("fullpp_count", 32'(count), 32'd3);
    for (int i = 2; i <= 4; i++) begin
      chk("fullpp_a", 32'(out_a), 32'(i));
      cycle(1'b0, '0, '0, 1'b1);
    end
    chk("fullpp_empty", 32'(count), 32'd0);

    // Steady push+pop with 2 held, crosses the pointer wrap.
    cycle(1'b1, 4'd12, 4'd2, 1'b0);
    cycle(1'b1, 4'd13, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      chk("steady_count", 32'(count), 32'd2);
    end
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);

    // Mid-stream async reset.
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 4), 4'd5, 1'b0);
    cycle(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(out_valid), 32'd0);
    chk("arst_count",    32'(count),     32'd0);
    chk("arst_in_ready", 32'(in_ready),  32'd1);
    #1 rst_n = 1'b1;
    cycle(1'b1, 4'hA, 4'h5, 1'b0);
    chk("arst_head", 32'(out_a), 32'hA);
    chk("arst_cnt1", 32'(count), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_operand_queue.md
MOD_OPERAND_QUEUE -- requirements
Module: mod_operand_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the queue entry count; it must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the producer offers an operand pair.
REQ-006 SHALL have port in_ready, output, 1 bit: the queue accepts a pair this cycle.
REQ-007 SHALL have port in_a, input, WIDTH bits: dividend.
REQ-008 SHALL have port in_b, input, WIDTH bits: divisor.
REQ-009 SHALL have port out_valid, output, 1 bit: a head entry is presented to the downstream remainder stage.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream stage consumes the head this cycle.
REQ-011 SHALL have port out_a, output, WIDTH bits: head dividend.
REQ-012 SHALL have port out_b, output, WIDTH bits: head divisor.
REQ-013 SHALL have port out_f, output, 1 bit: XOR-reduction (odd parity) of the head dividend; this is the select that enables the remainder.
REQ-014 SHALL have port out_zero, output, 1 bit: the head divisor equals 0.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored entries.

Function
REQ-016 SHALL accept a push when in_valid and in_ready are both 1 at the rising clock edge.
REQ-017 SHALL pop the head entry when out_valid and out_ready are both 1 at the rising clock edge.
REQ-018 SHALL drive in_ready = (count < DEPTH) and out_valid = (count != 0); both are derived combinationally from registered count only.
REQ-019 SHALL compute f = ^in_a and zero = (in_b == 0) at push time and store them with the entry; out_f and out_zero come from storage, not from recomputation.
REQ-020 SHALL have push-to-output latency of 1 cycle: an entry pushed into an empty queue appears on out_* with out_valid=1 in the next cycle, with no same-cycle fall-through.
REQ-021 SHALL perform push and pop in the same cycle when not full and not empty: count is unchanged, and the new entry lands behind the remaining entries.
REQ-022 SHALL refuse a push when full (in_ready=0), even if a pop occurs in the same cycle; the pushed data is ignored and count becomes DEPTH-1.
REQ-023 SHALL treat out_ready while empty as a no-op: count stays 0 and the pointers do not move.
REQ-024 SHALL ignore in_a and in_b while in_valid=0 or in_ready=0.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH, preserving FIFO order across the wrap.
REQ-026 SHALL force out_a, out_b, out_f and out_zero to 0 whenever out_valid=0.
REQ-027 SHALL hold the head entry stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, asynchronously on rst_n=0, clear count and both pointers to 0, giving in_ready=1, out_valid=0 and all out_* = 0.
REQ-029 SHALL discard all stored entries on a reset asserted mid-operation; storage contents need not be cleared, because REQ-026 masks the outputs.
REQ-030 SHALL accept its first push at the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL take the WIDTH and DEPTH defaults and the entry record type {a, b, f, zero} from a shared package mod_pkg, which the remainder stage also uses.
REQ-032 SHALL place the storage array with its write port and read port in one sub-module, mod_queue_mem; pointer and count control stays in mod_operand_queue.

Verification
REQ-033 SHALL check: after reset, push a=4'b0111, b=4'd3 -> next cycle out_valid=1, out_a=7, out_b=3, out_f=1, out_zero=0, count=1.
REQ-034 SHALL check: push a=4'b0011, b=0 -> out_f=0, out_zero=1; pop -> out_valid=0 and all out_* = 0.
REQ-035 SHALL check: with out_ready=0, push 5 pairs at DEPTH=4 -> the first 4 are accepted, in_ready=0 after the 4th, and the 5th is dropped; draining yields the first 4 in order.
REQ-036 SHALL check: full queue with in_valid=1 and out_ready=1 in the same cycle -> pop only, count=3, and the push is not taken.
REQ-037 SHALL check: continuous push+pop for 10 cycles with 2 entries held -> count stays 2, order is preserved across pointer wrap, and f matches ^a for every entry.
REQ-038 SHALL check: rst_n pulsed low mid-stream with 3 entries held -> out_valid=0 and count=0 immediately, without waiting for a clock edge; afterwards, the first push after release is the next head.
